// File: rtl/sub_nibble_sequencer.sv
// Multi-cycle subtractor: streams operand nibbles LSB-first through an external
// 4-bit subtract slice, chaining the borrow, then presents the result and ALU flags.
module sub_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic [3:0]       nib_a,
  output logic [3:0]       nib_b,
  output logic             nib_bin,
  input  logic [3:0]       nib_diff,
  input  logic             nib_bout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = $clog2(NIBBLES);
  localparam int MSB     = WIDTH - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [IDXW+1:0]  nib_base;

  assign nib_base = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    in_ready  = 1'b0;
    nib_a     = 4'h0;
    nib_b     = 4'h0;
    nib_bin   = 1'b0;
    out_valid = 1'b0;
    out_diff  = '0;
    out_bout  = 1'b0;
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    out_ovf   = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          borrow_d = in_bin;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // One slice pass per cycle; the slice's borrow-out feeds the next nibble.
        nib_a                 = a_q[nib_base +: 4];
        nib_b                 = b_q[nib_base +: 4];
        nib_bin               = borrow_q;
        diff_d[nib_base +: 4] = nib_diff;
        borrow_d              = nib_bout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_diff  = diff_q;
        out_bout  = borrow_q;
        out_zero  = (diff_q == '0);
        out_neg   = diff_q[MSB];
        out_ovf   = (a_q[MSB] != b_q[MSB]) && (diff_q[MSB] != a_q[MSB]);
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
